// File: rtl/serial_parity_tx_if.sv
// Handshake and serial-line bundle between the parity transmitter and its neighbours.
// The master side feeds words in; the slave side is the transmitter itself.
interface serial_parity_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_bit;
    logic              ser_valid;
    logic              frame_start;
    logic              frame_end;
    logic              busy;
    logic [15:0]       frames_sent;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_bit, ser_valid, frame_start, frame_end, busy, frames_sent
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_bit, ser_valid, frame_start, frame_end, busy, frames_sent
    );
endinterface

// File: rtl/serial_parity_tx.sv
// Serializes parallel words LSB-first and appends an even-parity bit per frame.
// Optional macro SERIAL_PARITY_TX_ERR_INJ_EN adds inj_err / frames_corrupted for parity corruption.
module serial_parity_tx #(
    parameter int   DATA_W     = 8,
    parameter int   GAP_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
    input  logic        inj_err,
    output logic [15:0] frames_corrupted,
`endif
    serial_parity_tx_if.slave bus
);
    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [3:0]      GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit              HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              ser_bit_q, ser_bit_d;
    logic              ser_valid_q, ser_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_end_q, frame_end_d;
    logic [15:0]       frames_sent_q, frames_sent_d;
    logic              inj_bit_s;

    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
    assign inj_bit_s = inj_err;
`else
    assign inj_bit_s = 1'b0;
`endif

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ser_bit     = ser_bit_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.frames_sent = frames_sent_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) state_d = ST_DATA;
                else              state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
                else                       state_d = ST_DATA;
            end
            ST_PARITY: begin
                if (HAS_GAP) state_d = ST_GAP;
                else         state_d = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                       state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; serial outputs are precomputed one cycle ahead.
    always_comb begin
        shift_d       = shift_q;
        parity_d      = parity_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        ser_bit_d     = IDLE_LEVEL;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frames_sent_d = frames_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shift_d       = bus.in_data >> 1'b1;
                    parity_d      = even_parity(bus.in_data) ^ inj_bit_s;
                    bit_cnt_d     = '0;
                    ser_bit_d     = bus.in_data[0];
                    ser_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_DATA: begin
                ser_valid_d = 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    ser_bit_d   = parity_q;
                    frame_end_d = 1'b1;
                end else begin
                    ser_bit_d = shift_q[0];
                    shift_d   = shift_q >> 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                frames_sent_d = frames_sent_q + 16'd1;
                gap_cnt_d     = 4'd0;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
            end
            default: begin
                ser_bit_d = IDLE_LEVEL;
            end
        endcase
    end

    // Datapath and registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q       <= '0;
            parity_q      <= 1'b0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= 4'd0;
            ser_bit_q     <= IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frames_sent_q <= 16'd0;
        end else begin
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ser_bit_q     <= ser_bit_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frames_sent_q <= frames_sent_d;
        end
    end

`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
    logic [15:0] frames_corrupted_q, frames_corrupted_d;

    // Corrupted-frame counter, bumped when a word is accepted with inj_err set.
    always_comb begin
        if ((state_q == ST_IDLE) && bus.in_valid && inj_err) begin
            frames_corrupted_d = frames_corrupted_q + 16'd1;
        end else begin
            frames_corrupted_d = frames_corrupted_q;
        end
    end

    // Corrupted-frame counter register.
    always_ff @(posedge clk) begin
        if (reset) frames_corrupted_q <= 16'd0;
        else       frames_corrupted_q <= frames_corrupted_d;
    end

    assign frames_corrupted = frames_corrupted_q;
`endif
endmodule

// File: doc/serial_parity_tx.md
Name: serial_parity_tx

Overview:
- Upstream stage of the serial even-parity checker.
- Accepts parallel words over a valid/ready handshake and serializes each word LSB-first, one bit per clock.
- Appends one even-parity bit to every word, so a correct frame always holds an even count of ones.
- Produces framing strobes and a frame counter for the downstream checker and the bench.

Parameters:
- DATA_W, 8, data bits per frame; legal range 1..32.
- GAP_CYCLES, 1, idle cycles inserted after each parity bit; legal range 0..15.
- IDLE_LEVEL, 1'b0, value driven on ser_bit whenever ser_valid = 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  parallel word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_bit  output  1  serial line bit.
- ser_valid  output  1  ser_bit carries a data or parity bit.
- frame_start  output  1  high with data bit 0.
- frame_end  output  1  high with the parity bit.
- busy  output  1  high in any state other than IDLE.
- frames_sent  output  16  count of completed frames.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: in_ready = 1, ser_bit = IDLE_LEVEL, ser_valid = 0, frame_start = 0, frame_end = 0, busy = 0, frames_sent = 0, FSM = IDLE.
- States: IDLE, DATA, PARITY, GAP.
- in_ready is high only in IDLE. It is combinational from state.
- Accept happens on a clock edge where in_valid && in_ready. in_data is latched into a DATA_W shift register. Parity is computed as XOR-reduce of in_data and latched with it. FSM goes to DATA.
- in_data and in_valid are ignored outside IDLE.
- Serial outputs are registered; ser_bit, ser_valid, frame_start and frame_end come from flops.
- Latency: bit 0 appears on the cycle after the accept edge.
- DATA state:
  - Drives bits 0..DATA_W-1 on consecutive cycles, ser_valid = 1.
  - frame_start = 1 only with bit 0.
  - A bit counter runs 0..DATA_W-1; after bit DATA_W-1 the FSM goes to PARITY.
  - For DATA_W = 1, DATA lasts exactly one cycle.
- PARITY state:
  - One cycle, ser_bit = latched parity, ser_valid = 1, frame_end = 1.
  - frames_sent increments on this cycle and wraps 16'hFFFF -> 16'h0000.
  - Next state is GAP if GAP_CYCLES > 0, otherwise IDLE.
- GAP state: lasts GAP_CYCLES cycles, ser_valid = 0, ser_bit = IDLE_LEVEL, then IDLE.
- Frame period with back-to-back valid input: 1 (accept) + DATA_W + 1 + GAP_CYCLES cycles.
- busy = 1 in DATA, PARITY and GAP.
- Reset mid-frame: the frame is aborted with no partial parity bit. All outputs take reset values on the next edge. The shift register contents are don't-care.
- in_valid may drop or in_data may change after the accept with no effect on the frame.

Optional Feature:
- Macro: SERIAL_PARITY_TX_ERR_INJ_EN.
- When defined: an extra input port inj_err (1 bit) is added.
  - If inj_err = 1 on the accept edge, that frame's parity bit is inverted.
  - An extra 16-bit output frames_corrupted counts such frames; it wraps and resets to 0.
- When undefined: neither port exists and parity is always correct.

Test Plan (DATA_W = 8, GAP_CYCLES = 1, IDLE_LEVEL = 0 unless noted):
- Accept 8'hA5 -> ser_bit 1,0,1,0,0,1,0,1 then parity 0. frame_start on the first bit, frame_end on the parity bit, frames_sent = 1.
- Accept 8'h07 -> ser_bit 1,1,1,0,0,0,0,0 then parity 1. One gap cycle with ser_valid = 0, then in_ready = 1.
- in_valid held high with 8'hFF, 8'h01 -> consecutive frames with parity 0 then 1. 11-cycle period (GAP_CYCLES = 1). in_ready low for 10 cycles after each accept.
- Assert reset on the 4th data bit of 8'h3C -> next cycle ser_valid = 0, busy = 0, frames_sent = 0, and no frame_end pulse.
- Force frames_sent to 16'hFFFF, send one frame -> frames_sent = 16'h0000.
- With SERIAL_PARITY_TX_ERR_INJ_EN, send 8'hA5 with inj_err = 1 -> parity bit 1, frames_corrupted = 1. The downstream checker flags the error.
